// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: output slot plus one skid slot, registered ready, flush squash.
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CTRL_W-1:0] r_out_ctrl;
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic              r_in_ready;

   logic              w_in_fire;
   logic              w_out_free;
   logic              w_out_valid_nxt;
   logic [DATA_W-1:0] w_out_data_nxt;
   logic [CTRL_W-1:0] w_out_ctrl_nxt;
   logic              w_skid_valid_nxt;
   logic              w_skid_load;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_free = ~r_out_valid | out_ready;

   // Skid slot drains first so entries keep acceptance order.
   always_comb begin
      w_out_valid_nxt  = r_out_valid;
      w_out_data_nxt   = r_out_data;
      w_out_ctrl_nxt   = r_out_ctrl;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_load      = 1'b0;
      if (flush) begin
         w_out_valid_nxt  = 1'b0;
         w_out_ctrl_nxt   = '0;
         w_skid_valid_nxt = 1'b0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            w_out_valid_nxt  = 1'b1;
            w_out_data_nxt   = r_skid_data;
            w_out_ctrl_nxt   = r_skid_ctrl;
            w_skid_valid_nxt = 1'b0;
         end else if (w_in_fire) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = in_data;
            w_out_ctrl_nxt  = in_ctrl;
         end else begin
            w_out_valid_nxt = 1'b0;
            w_out_ctrl_nxt  = '0;
         end
      end else if (w_in_fire) begin
         w_skid_valid_nxt = 1'b1;
         w_skid_load      = 1'b1;
      end
   end

   // Output slot and control state; ready is registered off the next skid occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_ctrl   <= '0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_out_valid  <= w_out_valid_nxt;
         r_out_data   <= w_out_data_nxt;
         r_out_ctrl   <= w_out_ctrl_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= ~w_skid_valid_nxt;
      end
   end

   // Skid payload is only meaningful while r_skid_valid is set.
   always_ff @(posedge clk) begin
      if (w_skid_load) begin
         r_skid_data <= in_data;
         r_skid_ctrl <= in_ctrl;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ctrl  = r_out_ctrl;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (r_out_valid & ~out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
         if (~r_out_valid) r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then randomized traffic vs. a queue model.
module tb_pipe_stage_reg;
   localparam int DATA_W = 96;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;
`endif

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] c;
   } entry_t;

   entry_t exp_q[$];
   int     n_vec = 0;
   int     n_err = 0;
   bit     armed = 1'b0;
   int     m_stall = 0;
   int     m_bubble = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: entries accepted and not yet delivered, in order.
   always @(negedge clk) begin
      int     sz;
      entry_t e;
      sz = exp_q.size();
      if (armed) begin
         check("out_valid", out_valid, sz > 0);
         check("in_ready", in_ready, sz < 2);
         if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_PERF_EN
         check("stall_cnt", stall_cnt, m_stall);
         check("bubble_cnt", bubble_cnt, m_bubble);
`endif
      end
      if (rst) begin
         exp_q.delete();
         m_stall  = 0;
         m_bubble = 0;
         armed    = 1'b1;
      end else begin
         if (sz > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
         if (sz == 0 && m_bubble < CNT_MAX) m_bubble++;
         if (sz > 0 && out_ready) begin
            e = exp_q.pop_front();
            if (armed) begin
               check("out_data", out_data, e.d);
               check("out_ctrl", out_ctrl, e.c);
            end
         end
         if (flush) exp_q.delete();
         else if (in_valid && sz < 2) exp_q.push_back({in_data, in_ctrl});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic hold;
      rst = 1'b1; in_valid = 1'b1; in_ctrl = '1; in_data = rnd_data();
      flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0; in_valid = 1'b0;
      tick();

      // Streaming 1..8 back-to-back
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'($urandom);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();

      // Back-pressure: A held, B in skid, C waits
      in_valid = 1'b1; in_data = 'hA; in_ctrl = 16'h00A1; out_ready = 1'b0;
      tick();
      in_data = 'hB; in_ctrl = 16'h00B2;
      tick();
      check("bp_in_ready_low", in_ready, 0);
      in_data = 'hC; in_ctrl = 16'h00C3;
      repeat (3) tick();
      out_ready = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      repeat (3) tick();

      // Flush with both slots full
      out_ready = 1'b0; in_valid = 1'b1; in_data = 'hE; in_ctrl = 16'h0E0E;
      tick();
      in_data = 'hF; in_ctrl = 16'h0F0F;
      tick();
      flush = 1'b1; in_data = 'hD; in_ctrl = 16'h0D0D;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_out_ctrl", out_ctrl, 0);
      check("flush_in_ready", in_ready, 1);
      // Flush with concurrent in_fire while skid is free
      in_valid = 1'b1; in_data = 'h11; in_ctrl = 16'h1111;
      tick();
      flush = 1'b1; in_data = 'hD; in_ctrl = 16'h0D0D;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush2_out_valid", out_valid, 0);

      // Bubble drain with in_ctrl all ones
      out_ready = 1'b1; in_ctrl = '1;
      repeat (4) tick();

`ifdef PIPE_STAGE_PERF_EN
      rst = 1'b1; tick(); rst = 1'b0;
      in_valid = 1'b1; in_data = 'h55; in_ctrl = 16'h5555; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check("stall_5", stall_cnt, 5);
      repeat (15) tick();
      check("stall_sat", stall_cnt, CNT_MAX);
      flush = 1'b1; tick(); flush = 1'b0;
      check("stall_after_flush", stall_cnt, CNT_MAX);
      out_ready = 1'b1;
      repeat (2) tick();
`endif

      // Randomized traffic; the source holds an entry until it is accepted.
      hold = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         flush = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if (!hold) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = rnd_data();
            in_ctrl  = CTRL_W'($urandom);
         end
         hold = in_valid && !in_ready && !rst;
         tick();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
